// File: rtl/proc_hier_pkg.sv
// Shared definitions for the proc_hier single-cycle 16-bit processor:
// opcode constants, ALU function codes, the machine word type, memory
// geometry and immediate sign-extension helpers.
package proc_hier_pkg;

   localparam int DATA_W    = 16;
   localparam int MEM_DEPTH = 256;
   localparam int NUM_REGS  = 8;

   typedef logic [DATA_W-1:0] word_t;

   typedef enum logic [4:0] {
      OP_HALT = 5'b00000,
      OP_NOP  = 5'b00001,
      OP_ADDI = 5'b01000,
      OP_LBI  = 5'b11000,
      OP_ALU  = 5'b11011,
      OP_LD   = 5'b10001,
      OP_ST   = 5'b10000,
      OP_BEQZ = 5'b01100,
      OP_J    = 5'b00100
   } opcode_e;

   typedef enum logic [1:0] {
      ALU_ADD  = 2'b00,   // Rs + Rt
      ALU_SUB  = 2'b01,   // Rt - Rs
      ALU_XOR  = 2'b10,   // Rs ^ Rt
      ALU_ANDN = 2'b11    // Rs & ~Rt
   } aluFunc_e;

   function automatic word_t sext5(input logic signed [4:0] v);
      return word_t'(16'(v));
   endfunction

   function automatic word_t sext8(input logic signed [7:0] v);
      return word_t'(16'(v));
   endfunction

   function automatic word_t sext11(input logic signed [10:0] v);
      return word_t'(16'(v));
   endfunction

endpackage

// File: rtl/proc_hier_regfile.sv
// Eight 16-bit general registers: two combinational read ports and one
// write port committed on the rising edge. Reads see the pre-edge value,
// so an instruction reading its own destination gets the old contents.
module proc_hier_regfile
   import proc_hier_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [2:0] rdAddrA,
   input  logic [2:0] rdAddrB,
   output word_t      rdDataA,
   output word_t      rdDataB,
   input  logic       wrEn,
   input  logic [2:0] wrAddr,
   input  word_t      wrData
);

   word_t regs [NUM_REGS];

   assign rdDataA = regs[rdAddrA];
   assign rdDataB = regs[rdAddrB];

   // Register storage: cleared by reset, one write per edge
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs[i] <= '0;
         end
      end else if (wrEn) begin
         regs[wrAddr] <= wrData;
      end
   end

endmodule

// File: rtl/proc_hier_top.sv
// Single-cycle 16-bit processor with internal 256-word instruction and
// data memories. All trace outputs are decoded combinationally from the
// instruction at the current PC. Optional cycle/instruction counters are
// built only when PROC_HIER_COUNTERS_EN is defined; otherwise both
// counter outputs read 0.
module proc_hier_top
   import proc_hier_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   output logic [15:0] pc,
   output logic [15:0] inst,
   output logic        reg_write,
   output logic [2:0]  write_register,
   output logic [15:0] write_data,
   output logic        mem_read,
   output logic        mem_write,
   output logic [15:0] mem_address,
   output logic [15:0] mem_data_in,
   output logic [15:0] mem_data_out,
   output logic        halt,
   output logic [31:0] cycle_count,
   output logic [31:0] inst_count
);

   // Instruction memory is preloaded externally; the core only reads it.
   word_t imem [MEM_DEPTH];
   word_t dmem [MEM_DEPTH];

   word_t      pcReg;
   logic       halted;
   opcode_e    opcode;
   aluFunc_e   aluFunc;
   word_t      rsData;
   word_t      rtData;
   word_t      effAddr;
   word_t      loadData;
   word_t      nextPc;
   logic       haltNow;
   logic       regWrite;
   logic [2:0] writeReg;
   word_t      writeData;
   logic       memRead;
   logic       memWrite;

   assign pc       = pcReg;
   assign inst     = imem[pcReg[8:1]];
   assign opcode   = opcode_e'(inst[15:11]);
   assign aluFunc  = aluFunc_e'(inst[1:0]);
   assign effAddr  = rsData + sext5(inst[4:0]);
   assign loadData = dmem[effAddr[8:1]];

   proc_hier_regfile uRegfile (
      .clk     (clk),
      .rst_n   (rst_n),
      .rdAddrA (inst[10:8]),
      .rdAddrB (inst[7:5]),
      .rdDataA (rsData),
      .rdDataB (rtData),
      .wrEn    (regWrite),
      .wrAddr  (writeReg),
      .wrData  (writeData)
   );

   // Decode: architectural effects and next PC of the current instruction
   always_comb begin
      nextPc    = pcReg + 16'd2;
      haltNow   = 1'b0;
      regWrite  = 1'b0;
      writeReg  = 3'd0;
      writeData = '0;
      memRead   = 1'b0;
      memWrite  = 1'b0;
      case (opcode)
         OP_HALT: begin
            haltNow = 1'b1;
            nextPc  = pcReg;
         end
         OP_ADDI: begin
            regWrite  = 1'b1;
            writeReg  = inst[7:5];
            writeData = effAddr;
         end
         OP_LBI: begin
            regWrite  = 1'b1;
            writeReg  = inst[10:8];
            writeData = sext8(inst[7:0]);
         end
         OP_ALU: begin
            regWrite = 1'b1;
            writeReg = inst[4:2];
            case (aluFunc)
               ALU_ADD:  writeData = rsData + rtData;
               ALU_SUB:  writeData = rtData - rsData;
               ALU_XOR:  writeData = rsData ^ rtData;
               ALU_ANDN: writeData = rsData & ~rtData;
            endcase
         end
         OP_LD: begin
            memRead   = 1'b1;
            regWrite  = 1'b1;
            writeReg  = inst[7:5];
            writeData = loadData;
         end
         OP_ST: begin
            memWrite = 1'b1;
         end
         OP_BEQZ: begin
            if (rsData == '0) begin
               nextPc = pcReg + 16'd2 + sext8(inst[7:0]);
            end
         end
         OP_J: begin
            nextPc = pcReg + 16'd2 + sext11(inst[10:0]);
         end
         default: begin
         end
      endcase
      // Once halted nothing architectural may change.
      if (halted) begin
         nextPc   = pcReg;
         regWrite = 1'b0;
         memRead  = 1'b0;
         memWrite = 1'b0;
      end
   end

   assign reg_write      = regWrite;
   assign write_register = writeReg;
   assign write_data     = writeData;
   assign mem_read       = memRead;
   assign mem_write      = memWrite;
   assign mem_address    = (memRead || memWrite) ? effAddr : '0;
   assign mem_data_in    = rtData;
   assign mem_data_out   = loadData;
   assign halt           = haltNow || halted;

   // PC and halted flag: frozen once a HALT has committed
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pcReg  <= '0;
         halted <= 1'b0;
      end else if (!halted) begin
         pcReg <= nextPc;
         if (haltNow) begin
            halted <= 1'b1;
         end
      end
   end

   // Data memory store port; contents survive reset, no store while in reset
   always_ff @(posedge clk) begin
      if (rst_n && memWrite) begin
         dmem[effAddr[8:1]] <= rtData;
      end
   end

`ifdef PROC_HIER_COUNTERS_EN
   logic [31:0] cycleCnt;
   logic [31:0] instCnt;

   // Counters: cycles always advance, instructions only when something commits
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cycleCnt <= '0;
         instCnt  <= '0;
      end else begin
         cycleCnt <= cycleCnt + 32'd1;
         if ((regWrite || memWrite || haltNow) && !halted) begin
            instCnt <= instCnt + 32'd1;
         end
      end
   end

   assign cycle_count = cycleCnt;
   assign inst_count  = instCnt;
`else
   assign cycle_count = '0;
   assign inst_count  = '0;
`endif

endmodule

// File: tb/tb_proc_hier_top.sv
// Self-checking bench for proc_hier_top: directed program for the key
// instruction behaviours, then random programs checked against an
// instruction-level reference model, including an asynchronous reset
// asserted between clock edges.
module tb_proc_hier_top;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] pc, inst, write_data, mem_address, mem_data_in, mem_data_out;
   logic        reg_write, mem_read, mem_write, halt;
   logic [2:0]  write_register;
   logic [31:0] cycle_count, inst_count;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   proc_hier_top dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .pc             (pc),
      .inst           (inst),
      .reg_write      (reg_write),
      .write_register (write_register),
      .write_data     (write_data),
      .mem_read       (mem_read),
      .mem_write      (mem_write),
      .mem_address    (mem_address),
      .mem_data_in    (mem_data_in),
      .mem_data_out   (mem_data_out),
      .halt           (halt),
      .cycle_count    (cycle_count),
      .inst_count     (inst_count)
   );

   // Reference model state
   logic [15:0] img  [256];
   logic [15:0] mR   [8];
   logic [15:0] mMem [256];
   logic [15:0] mPc;
   bit          mHalted;
   int unsigned mCyc, mInst;

   // Expected values for the current cycle
   logic [15:0] eInst, eWd, eAddr, eNextPc, eStore, eLoad;
   logic        eRw, eRd, eWr, eHalt;
   logic [2:0]  eWreg;

   function automatic logic [15:0] sx(input int v, input int bits);
      int s;
      s = v & ((1 << bits) - 1);
      if (s >= (1 << (bits - 1))) s = s - (1 << bits);
      return 16'(s);
   endfunction

   task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic modelReset();
      mPc = 16'h0000;
      mHalted = 1'b0;
      mCyc = 0;
      mInst = 0;
      for (int i = 0; i < 8; i++) mR[i] = 16'h0000;
   endtask

   task automatic modelEval();
      int op;
      logic [15:0] a, b;
      eInst = img[mPc[8:1]];
      op = int'(eInst[15:11]);
      a = mR[eInst[10:8]];
      b = mR[eInst[7:5]];
      eRw = 0; eRd = 0; eWr = 0; eHalt = 0; eWreg = 0;
      eWd = 0; eAddr = 0; eStore = 0; eLoad = 0;
      eNextPc = mPc + 16'd2;
      if (mHalted) begin
         eHalt = 1;
         eNextPc = mPc;
         return;
      end
      case (op)
         5'b00000: begin eHalt = 1; eNextPc = mPc; end
         5'b01000: begin eRw = 1; eWreg = eInst[7:5]; eWd = a + sx(int'(eInst[4:0]), 5); end
         5'b11000: begin eRw = 1; eWreg = eInst[10:8]; eWd = sx(int'(eInst[7:0]), 8); end
         5'b11011: begin
            eRw = 1;
            eWreg = eInst[4:2];
            case (eInst[1:0])
               2'd0: eWd = a + b;
               2'd1: eWd = b - a;
               2'd2: eWd = a ^ b;
               default: eWd = a & ~b;
            endcase
         end
         5'b10001: begin
            eRd = 1; eRw = 1; eWreg = eInst[7:5];
            eAddr = a + sx(int'(eInst[4:0]), 5);
            eLoad = mMem[eAddr[8:1]];
            eWd = eLoad;
         end
         5'b10000: begin
            eWr = 1;
            eAddr = a + sx(int'(eInst[4:0]), 5);
            eStore = b;
         end
         5'b01100: if (a == 16'h0000) eNextPc = mPc + 16'd2 + sx(int'(eInst[7:0]), 8);
         5'b00100: eNextPc = mPc + 16'd2 + sx(int'(eInst[10:0]), 11);
         default: ;
      endcase
   endtask

   task automatic modelCommit();
      if (!mHalted && (eRw || eWr || eHalt)) mInst++;
      mCyc++;
      if (eRw) mR[eWreg] = eWd;
      if (eWr) mMem[eAddr[8:1]] = eStore;
      if (eHalt) mHalted = 1'b1;
      mPc = eNextPc;
   endtask

   task automatic checkAll();
      modelEval();
      checkVal("pc", pc, mPc);
      checkVal("inst", inst, eInst);
      checkVal("reg_write", reg_write, eRw);
      checkVal("mem_read", mem_read, eRd);
      checkVal("mem_write", mem_write, eWr);
      checkVal("halt", halt, eHalt);
      if (eRw) begin
         checkVal("write_register", write_register, eWreg);
         checkVal("write_data", write_data, eWd);
      end
      if (eRd || eWr) checkVal("mem_address", mem_address, eAddr);
      if (eWr) checkVal("mem_data_in", mem_data_in, eStore);
      if (eRd) checkVal("mem_data_out", mem_data_out, eLoad);
`ifdef PROC_HIER_COUNTERS_EN
      checkVal("cycle_count", cycle_count, mCyc);
      checkVal("inst_count", inst_count, mInst);
`else
      checkVal("cycle_count", cycle_count, 32'd0);
      checkVal("inst_count", inst_count, 32'd0);
`endif
   endtask

   // Check this cycle, then advance one edge (model frozen while in reset)
   task automatic step();
      checkAll();
      @(posedge clk);
      if (rst_n) modelCommit();
      #1;
   endtask

   task automatic loadImage();
      for (int i = 0; i < 256; i++) dut.imem[i] = img[i];
   endtask

   task automatic directedImage(input bit nz);
      for (int i = 0; i < 256; i++) img[i] = {5'b00001, 11'd0};
      img[0] = {5'b11000, 3'd1, 8'd5};                 // LBI R1,5
      img[1] = {5'b11000, 3'd2, 8'd3};                 // LBI R2,3
      img[2] = {5'b11011, 3'd1, 3'd2, 3'd3, 2'b01};    // R3 = R2 - R1
      img[3] = {5'b10000, 3'd0, 3'd1, 5'd4};           // ST R1,[R0+4]
      img[4] = {5'b10001, 3'd0, 3'd4, 5'd4};           // LD R4,[R0+4]
      img[5] = {5'b01100, (nz ? 3'd1 : 3'd0), 8'd4};   // BEQZ Rs,+4
      img[8] = 16'h0000;                               // HALT at 0x0010
   endtask

   function automatic logic [15:0] genInst();
      logic [4:0] undef [4];
      undef[0] = 5'b11111; undef[1] = 5'b00010; undef[2] = 5'b10101; undef[3] = 5'b01111;
      case ($urandom_range(0, 9))
         0: return {5'b01000, 3'($urandom_range(0, 7)), 3'($urandom_range(1, 7)), 5'($urandom)};
         1: return {5'b11000, 3'($urandom_range(1, 7)), 8'($urandom)};
         2, 3: return {5'b11011, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                       3'($urandom_range(1, 7)), 2'($urandom)};
         4: return {5'b10001, 3'd0, 3'($urandom_range(1, 7)), 5'($urandom)};
         5: return {5'b10000, 3'd0, 3'($urandom_range(0, 7)), 5'($urandom)};
         6: return {5'b01100, 3'($urandom_range(0, 7)), 8'($urandom)};
         7: return {5'b00100, 11'($urandom)};
         8: return {undef[$urandom_range(0, 3)], 11'($urandom)};
         default: return ($urandom_range(0, 7) == 0) ? 16'h0000 : {5'b00001, 11'($urandom)};
      endcase
   endfunction

   // Random program: a store prologue initialises every word reachable by
   // R0-based loads (R0 is never a destination, so it stays zero).
   task automatic randomImage();
      for (int k = 0; k < 16; k++) img[k] = {5'b10000, 3'd0, 3'd0, 5'(-16 + 2 * k)};
      for (int i = 16; i < 256; i++) img[i] = genInst();
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mMem[i] = 16'h0000;

      // Directed run A: taken BEQZ, then HALT
      rst_n = 1'b0;
      directedImage(1'b0);
      loadImage();
      modelReset();
      repeat (2) @(posedge clk);
      #1;
      checkVal("rst_pc", pc, 16'h0000);
      checkVal("rst_cycle_count", cycle_count, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      checkVal("lbi_reg_write", reg_write, 1'b1);
      checkVal("lbi_write_register", write_register, 3'd1);
      checkVal("lbi_write_data", write_data, 16'h0005);
      step();
      checkVal("lbi_pc_next", pc, 16'h0002);
      step();
      checkVal("alu_sub", write_data, 16'hFFFE);
      step();
      checkVal("st_mem_write", mem_write, 1'b1);
      checkVal("st_addr", mem_address, 16'h0004);
      checkVal("st_data", mem_data_in, 16'h0005);
      step();
      checkVal("ld_mem_read", mem_read, 1'b1);
      checkVal("ld_mem_data_out", mem_data_out, 16'h0005);
      checkVal("ld_write_data", write_data, 16'h0005);
      step();
      checkVal("beqz_pc", pc, 16'h000A);
      step();
      checkVal("beqz_taken_pc", pc, 16'h0010);
      checkVal("halt_decode", halt, 1'b1);
      step();
      for (int c = 0; c < 5; c++) begin
         checkVal("halt_held", halt, 1'b1);
         checkVal("halt_pc", pc, 16'h0010);
         checkVal("halt_no_reg_write", reg_write, 1'b0);
         checkVal("halt_no_mem_write", mem_write, 1'b0);
`ifdef PROC_HIER_COUNTERS_EN
         checkVal("halt_inst_count", inst_count, 32'd6);
`endif
         step();
      end

      // Directed run B: BEQZ with nonzero Rs falls through
      #2;
      rst_n = 1'b0;
      directedImage(1'b1);
      loadImage();
      modelReset();
      @(negedge clk);
      rst_n = 1'b1;
      repeat (6) step();
      checkVal("beqz_not_taken_pc", pc, 16'h000C);

      // Random programs, first one with an asynchronous mid-program reset
      for (int p = 0; p < 3; p++) begin
         #2;
         rst_n = 1'b0;
         randomImage();
         loadImage();
         modelReset();
         @(negedge clk);
         rst_n = 1'b1;
         for (int c = 0; c < 250; c++) begin
            step();
            if (p == 0 && c == 120) begin
               #2;
               rst_n = 1'b0;
               #1;
               modelReset();
               checkVal("async_rst_pc", pc, 16'h0000);
               for (int r = 0; r < 8; r++) checkVal("async_rst_reg", dut.uRegfile.regs[r], 16'h0000);
               step();
               #2;
               rst_n = 1'b1;
            end
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
